// File: rtl/rr_req_queue.sv
// Per-client request FIFOs feeding a round-robin arbiter.
// Granted FIFO head is popped onto one registered output channel.
module rr_req_queue #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        in_valid,
  input  logic [NUM_CLIENTS*DATA_W-1:0] in_data,
  output logic [NUM_CLIENTS-1:0]        in_ready,
  output logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        grant,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_CLIENTS)-1:0] out_id,
  output logic                          grant_err
);

  localparam int NC  = NUM_CLIENTS;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int IDW = $clog2(NUM_CLIENTS);

  logic [DATA_W-1:0] mem [NC][DEPTH];
  logic [AW-1:0]     rd_ptr [NC];
  logic [AW-1:0]     wr_ptr [NC];
  logic [CW-1:0]     count  [NC];

  logic [NC-1:0]  push;
  logic [NC-1:0]  pop;
  logic           onehot;
  logic           multi;
  logic [IDW-1:0] pop_idx;
  logic [DATA_W-1:0] head;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      in_ready[i] = (count[i] != CW'(DEPTH));
      req[i]      = (count[i] != '0);
    end
  end

  assign push   = in_valid & in_ready;
  assign onehot = (grant != '0) && ((grant & (grant - NC'(1))) == '0);
  assign multi  = (grant != '0) && !onehot;
  // stale one-hot grants mask off here via req
  assign pop    = onehot ? (grant & req) : '0;

  always_comb begin
    pop_idx = '0;
    for (int i = 0; i < NC; i++)
      if (grant[i]) pop_idx = IDW'(i);
  end

  assign head = mem[pop_idx][rd_ptr[pop_idx]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NC; i++)
      if (push[i])
        mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      grant_err <= 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      out_valid <= |pop;
      if (|pop) begin
        out_data <= head;
        out_id   <= pop_idx;
      end
      if (multi) grant_err <= 1'b1;
    end
  end

endmodule
